// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file operation scheduler.
// Also holds the read-modify-write ALU used in the READ -> WRITE handoff.
package rf_sched_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N_REQ  = 2;

    typedef enum logic [2:0] {
        OpNop = 3'd0,
        OpRd1 = 3'd1,
        OpRd2 = 3'd2,
        OpWr  = 3'd3,
        OpAdd = 3'd4,
        OpSub = 3'd5,
        OpShl = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        CmdIdle  = 2'd0,
        CmdRead  = 2'd1,
        CmdWrite = 2'd2
    } rf_cmd_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } state_e;

    // Shift amount is the full 16-bit operand: anything >= 16 clears the result.
    function automatic logic [DATA_W-1:0] alu_result(input op_e op,
                                                     input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] res;
        case (op)
            OpAdd:   res = a + b;
            OpSub:   res = a - b;
            OpShl:   res = (|b[DATA_W-1:4]) ? '0 : (a << b[3:0]);
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/rf_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last. The history only moves on accept.
module rf_sched_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_id_o,
    output logic       gnt_valid_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = (req_i == 2'b11) ? ~last_q : req_i[1];
        last_d      = last_q;
        if (accept_i && gnt_valid_o) begin
            last_d = gnt_id_o;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_op_scheduler.sv
// Arbitrates two requesters and sequences each accepted op as timed
// register-file READ/WRITE commands, returning data with a one-cycle pulse.
module rf_op_scheduler
    import rf_sched_pkg::*;
#(
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [5:0]  req_op,
    input  logic [9:0]  req_ra,
    input  logic [9:0]  req_rb,
    input  logic [9:0]  req_wa,
    input  logic [31:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [15:0] rsp_data_a,
    output logic [15:0] rsp_data_b,
    output logic        busy,
    output logic [1:0]  rf_cmd,
    output logic [4:0]  rf_ra,
    output logic [4:0]  rf_rb,
    output logic [4:0]  rf_wa,
    output logic [15:0] rf_wdata,
    input  logic [15:0] rf_rdata_a,
    input  logic [15:0] rf_rdata_b
);

    localparam int unsigned MaxLat = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int unsigned CntW   = $clog2(MaxLat + 1);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic [DATA_W-1:0] rsp_a_q, rsp_a_d, rsp_b_q, rsp_b_d;
    logic              id_q, id_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              gnt_id;
    logic              gnt_valid;
    logic              accept;
    logic [2:0]        sel_op;
    logic [DATA_W-1:0] alu_res;

    assign accept  = (state_q == StIdle) && gnt_valid;
    assign sel_op  = gnt_id ? req_op[5:3] : req_op[2:0];
    assign alu_res = alu_result(op_q, rf_rdata_a, rf_rdata_b);

    rf_sched_rr_arb2 u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_valid),
        .accept_i    (accept),
        .gnt_id_o    (gnt_id),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rsp_a_d = rsp_a_q;
        rsp_b_d = rsp_b_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d    = op_e'(sel_op);
                    ra_d    = gnt_id ? req_ra[9:5] : req_ra[4:0];
                    rb_d    = gnt_id ? req_rb[9:5] : req_rb[4:0];
                    wa_d    = gnt_id ? req_wa[9:5] : req_wa[4:0];
                    wd_d    = gnt_id ? req_wdata[31:16] : req_wdata[15:0];
                    id_d    = gnt_id;
                    rsp_a_d = '0;
                    rsp_b_d = '0;
                    cnt_d   = '0;
                    case (op_e'(sel_op))
                        OpRd1, OpRd2, OpAdd, OpSub, OpShl: state_d = StRead;
                        OpWr:                              state_d = StWrite;
                        default:                           state_d = StResp;
                    endcase
                end
            end
            StRead: begin
                if (cnt_q == CntW'(READ_LAT - 1)) begin
                    cnt_d = '0;
                    case (op_q)
                        OpRd1: begin
                            rsp_a_d = rf_rdata_a;
                            state_d = StResp;
                        end
                        OpRd2: begin
                            rsp_a_d = rf_rdata_a;
                            rsp_b_d = rf_rdata_b;
                            state_d = StResp;
                        end
                        default: begin
                            // ALU ops: the result is both the write data and the response.
                            wd_d    = alu_res;
                            rsp_a_d = alu_res;
                            state_d = StWrite;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: begin
                if (cnt_q == CntW'(WRITE_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            ra_q    <= '0;
            rb_q    <= '0;
            wa_q    <= '0;
            wd_q    <= '0;
            rsp_a_q <= '0;
            rsp_b_q <= '0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            rsp_a_q <= rsp_a_d;
            rsp_b_q <= rsp_b_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by state so every rf_* and rsp_* field is zero when unused.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_data_a = '0;
        rsp_data_b = '0;
        rf_cmd     = CmdIdle;
        rf_ra      = '0;
        rf_rb      = '0;
        rf_wa      = '0;
        rf_wdata   = '0;
        busy       = (state_q != StIdle);
        if (accept) begin
            req_ready = gnt_id ? 2'b10 : 2'b01;
        end
        case (state_q)
            StRead: begin
                rf_cmd = CmdRead;
                rf_ra  = ra_q;
                rf_rb  = rb_q;
            end
            StWrite: begin
                rf_cmd   = CmdWrite;
                rf_wa    = wa_q;
                rf_wdata = wd_q;
            end
            StResp: begin
                rsp_valid  = id_q ? 2'b10 : 2'b01;
                rsp_data_a = rsp_a_q;
                rsp_data_b = rsp_b_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_op_scheduler.sv
// Bench for rf_op_scheduler: register-file model, response scoreboard,
// a vector table of single ops, and sequences for ties and mid-op reset.
module tb_rf_op_scheduler;

    localparam int RL = 2;
    localparam int WL = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [9:0]  req_ra, req_rb, req_wa;
    logic [31:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_data_a, rsp_data_b;
    logic        busy;
    logic [1:0]  rf_cmd;
    logic [4:0]  rf_ra, rf_rb, rf_wa;
    logic [15:0] rf_wdata;
    logic [15:0] rf_rdata_a, rf_rdata_b;

    logic [15:0] mem [32];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    bit          abort = 1'b0;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        int          due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          id;
        logic [2:0]  op;
        logic [4:0]  ra, rb, wa;
        logic [15:0] wd, ea, eb;
        int          lat;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rf_rdata_a = mem[rf_ra];
    assign rf_rdata_b = mem[rf_rb];

    rf_op_scheduler #(.READ_LAT(RL), .WRITE_LAT(WL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_ra     (req_ra),
        .req_rb     (req_rb),
        .req_wa     (req_wa),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b),
        .busy       (busy),
        .rf_cmd     (rf_cmd),
        .rf_ra      (rf_ra),
        .rf_rb      (rf_rb),
        .rf_wa      (rf_wa),
        .rf_wdata   (rf_wdata),
        .rf_rdata_a (rf_rdata_a),
        .rf_rdata_b (rf_rdata_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input int id, input logic [2:0] op, input logic [4:0] ra,
                                input logic [4:0] rb, input logic [4:0] wa,
                                input logic [15:0] wd, input logic [15:0] ea,
                                input logic [15:0] eb, input int lat);
        vec_t v;
        v.id = id; v.op = op; v.ra = ra; v.rb = rb; v.wa = wa;
        v.wd = wd; v.ea = ea; v.eb = eb; v.lat = lat;
        return v;
    endfunction

    // Register-file model plus continuous protocol checks, sampled on negedge.
    task automatic monitor();
        int   wcnt = 0;
        int   rcnt = 0;
        exp_t e;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        forever begin
            @(negedge clk);
            if (rf_cmd == 2'd2) begin
                wcnt++;
                if (wcnt == WL) mem[rf_wa] = rf_wdata;
            end else begin
                if (wcnt != 0 && !abort) chk("write_len", wcnt, WL);
                wcnt = 0;
            end
            if (rf_cmd == 2'd1) begin
                rcnt++;
            end else begin
                if (rcnt != 0 && !abort) chk("read_len", rcnt, RL);
                rcnt = 0;
            end
            if (busy) chk("ready_while_busy", {30'd0, req_ready}, 0);
            if (rsp_valid == 2'b00) begin
                chk("rsp_idle_data", {rsp_data_a, rsp_data_b}, 0);
            end else if (sb.size() == 0) begin
                chk("rsp_unexpected", {30'd0, rsp_valid}, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", {30'd0, rsp_valid}, (e.id == 1) ? 2 : 1);
                chk("rsp_data_a", {16'd0, rsp_data_a}, {16'd0, e.a});
                chk("rsp_data_b", {16'd0, rsp_data_b}, {16'd0, e.b});
                chk("rsp_cycle", cyc, e.due);
            end
        end
    endtask

    task automatic issue(input vec_t v);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        req_op[3*v.id +: 3]     = v.op;
        req_ra[5*v.id +: 5]     = v.ra;
        req_rb[5*v.id +: 5]     = v.rb;
        req_wa[5*v.id +: 5]     = v.wa;
        req_wdata[16*v.id +: 16] = v.wd;
        req_valid[v.id]         = 1'b1;
        #1;
        while (!req_ready[v.id] && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept", {31'd0, req_ready[v.id]}, 1);
        if (req_ready[v.id]) begin
            e.id = v.id; e.a = v.ea; e.b = v.eb; e.due = cyc + v.lat;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid[v.id] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rf_cmd", {30'd0, rf_cmd}, 0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
        chk("rst_req_ready", {30'd0, req_ready}, 0);
        chk("rst_rf_fields", {1'b0, rf_ra, rf_rb, rf_wa, rf_wdata}, 0);
        chk("rst_rsp_data", {rsp_data_a, rsp_data_b}, 0);
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        exp_t e;
        int   n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_ra    = '0;
        req_rb    = '0;
        req_wa    = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        fork
            monitor();
        join_none
        do_reset();

        vt.push_back(mk(0, 3'd3, 0, 0, 3, 16'h1234, 0, 0, WL + 1));
        vt.push_back(mk(0, 3'd3, 0, 0, 4, 16'h0010, 0, 0, WL + 1));
        vt.push_back(mk(1, 3'd2, 3, 4, 0, 0, 16'h1234, 16'h0010, RL + 1));
        vt.push_back(mk(0, 3'd4, 3, 4, 5, 0, 16'h1244, 0, RL + WL + 1));
        vt.push_back(mk(1, 3'd1, 5, 0, 0, 0, 16'h1244, 0, RL + 1));
        vt.push_back(mk(0, 3'd5, 4, 3, 6, 0, 16'hEDDC, 0, RL + WL + 1));
        vt.push_back(mk(1, 3'd1, 6, 0, 0, 0, 16'hEDDC, 0, RL + 1));
        vt.push_back(mk(0, 3'd3, 0, 0, 7, 16'd20, 0, 0, WL + 1));
        vt.push_back(mk(1, 3'd6, 3, 7, 8, 0, 16'h0000, 0, RL + WL + 1));
        vt.push_back(mk(0, 3'd3, 0, 0, 9, 16'd3, 0, 0, WL + 1));
        vt.push_back(mk(1, 3'd6, 4, 9, 10, 0, 16'h0080, 0, RL + WL + 1));
        vt.push_back(mk(0, 3'd1, 10, 0, 0, 0, 16'h0080, 0, RL + 1));
        vt.push_back(mk(0, 3'd3, 0, 0, 12, 16'd15, 0, 0, WL + 1));
        vt.push_back(mk(1, 3'd6, 9, 12, 13, 0, 16'h8000, 0, RL + WL + 1));
        vt.push_back(mk(0, 3'd3, 0, 0, 0, 16'hBEEF, 0, 0, WL + 1));
        vt.push_back(mk(1, 3'd2, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, RL + 1));
        vt.push_back(mk(0, 3'd4, 0, 0, 0, 0, 16'h7DDE, 0, RL + WL + 1));
        vt.push_back(mk(1, 3'd1, 0, 0, 0, 0, 16'h7DDE, 0, RL + 1));
        vt.push_back(mk(1, 3'd7, 1, 2, 3, 16'hFFFF, 0, 0, 1));
        vt.push_back(mk(0, 3'd0, 1, 2, 3, 16'hFFFF, 0, 0, 1));
        vt.push_back(mk(1, 3'd1, 3, 0, 0, 0, 16'h1234, 0, RL + 1));
        vt.push_back(mk(0, 3'd3, 0, 0, 11, 16'h5A5A, 0, 0, WL + 1));

        foreach (vt[i]) begin
            issue(vt[i]);
            drain();
        end

        // Tie-break: both requesters hold valid, grants must alternate from 0.
        do_reset();
        @(negedge clk);
        req_op    = {3'd1, 3'd1};
        req_ra    = {5'd4, 5'd3};
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (req_ready == 2'b00 && n < 200) begin
                @(negedge clk);
                #1;
                n++;
            end
            chk("tie_grant", {30'd0, req_ready}, (k % 2 == 1) ? 2 : 1);
            e.id  = k % 2;
            e.a   = (k % 2 == 1) ? 16'h0010 : 16'h1234;
            e.b   = 16'h0;
            e.due = cyc + RL + 1;
            sb.push_back(e);
            @(negedge clk);
        end
        req_valid = 2'b00;
        drain();

        // Reset during the WRITE phase of an ADD into register 11.
        issue(mk(0, 3'd4, 3, 4, 11, 0, 16'h1244, 0, RL + WL + 1));
        abort = 1'b1;
        repeat (RL + 3) @(negedge clk);
        chk("pre_abort_cmd", {30'd0, rf_cmd}, 2);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        sb.delete();
        chk("abort_rf_cmd", {30'd0, rf_cmd}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_rsp_valid", {30'd0, rsp_valid}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (25) @(negedge clk);
        issue(mk(1, 3'd1, 11, 0, 0, 0, 16'h5A5A, 0, RL + 1));
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_op_scheduler.md
Name: rf_op_scheduler

Overview:
Two-requester scheduler for the 32x16 register file. It arbitrates round-robin between requesters and sequences each accepted operation as timed register-file READ and/or WRITE commands. It performs the ADD/SUB/SHL read-modify-write itself and returns read data or the result with a one-cycle response pulse. It sits between the operation issuers and the register file, replacing ad-hoc per-issuer cycle counters.

Parameters:
READ_LAT, 2, cycles rf_cmd=READ is held before rf_rdata_a/b are sampled (>=1)
WRITE_LAT, 16, cycles rf_cmd=WRITE is held to commit a write (>=1)

Ports:
clk  input  1  clock; all logic on posedge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  2  bit i: requester i has an operation pending
req_ready  output  2  bit i: one-cycle accept pulse to requester i
req_op  input  6  op for requester i at [3i+2:3i]
req_ra  input  10  source address A for requester i at [5i+4:5i]
req_rb  input  10  source address B for requester i at [5i+4:5i]
req_wa  input  10  destination address for requester i at [5i+4:5i]
req_wdata  input  32  write data for requester i at [16i+15:16i]
rsp_valid  output  2  bit i: one-cycle completion pulse for requester i
rsp_data_a  output  16  read value A, or result for ADD/SUB/SHL
rsp_data_b  output  16  read value B (RD2 only, else 0)
busy  output  1  high whenever state != IDLE
rf_cmd  output  2  register-file command: IDLE=0, READ=1, WRITE=2
rf_ra, rf_rb, rf_wa  output  5 each  register-file addresses
rf_wdata  output  16  register-file write data
rf_rdata_a, rf_rdata_b  input  16 each  register-file read data

Behaviour:
- Opcodes: NOP=0, RD1=1, RD2=2, WR=3, ADD=4, SUB=5, SHL=6. Code 7 is illegal and is treated as NOP.
- Reset (rst_n=0 at posedge):
  - state=IDLE; req_ready=0; rsp_valid=0; rsp_data_a/b=0; rf_cmd=IDLE; all rf_* addresses and data=0; last_grant=1.
  - Reset mid-operation abandons the operation: no rsp_valid, no further rf_cmd.
- States:
  - IDLE: if any req_valid, pick the winner and pulse req_ready[winner] for that cycle. Latch op, ra, rb, wa, wdata and the winner id.
    - RD1/RD2/ADD/SUB/SHL -> READ.
    - WR -> WRITE.
    - NOP/7 -> RESP.
  - READ: rf_cmd=READ, rf_ra/rf_rb driven, for exactly READ_LAT cycles. On the last cycle, sample rf_rdata_a/b.
    - RD1/RD2 -> RESP.
    - ADD/SUB/SHL -> WRITE with rf_wdata = result.
  - WRITE: rf_cmd=WRITE, rf_wa/rf_wdata held for exactly WRITE_LAT cycles, then -> RESP.
  - RESP: rsp_valid[id]=1 for one cycle with data on rsp_data_a/b, then -> IDLE.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester != last_grant wins; last_grant updates on every accept.
  - After reset, requester 0 wins the first tie.
- Requester contract:
  - Hold valid and fields stable until ready; drop valid the cycle after ready or present the next op.
  - req_ready is never high outside IDLE; there is one outstanding op total.
- Latency (accept cycle T = ready high):
  - RD1/RD2: rsp at T+READ_LAT+1.
  - WR: rsp at T+WRITE_LAT+1.
  - ALU ops: rsp at T+READ_LAT+WRITE_LAT+1 (T+19 with defaults).
  - NOP: rsp at T+1.
- Arithmetic, all mod 2^16, no flags:
  - ADD = a+b.
  - SUB = a-b.
  - SHL = a<<b, full 16-bit b; b>=16 gives 0.
- Response data:
  - RD1 returns a, rsp_data_b=0.
  - WR and NOP return 0/0.
  - rsp_data_* is valid only while rsp_valid, and is 0 otherwise.
- Boundary cases:
  - ra==rb is legal.
  - wa==ra is legal: the read completes before the write.
  - Address 0 is an ordinary register.
  - A new request arriving during busy waits in IDLE arbitration.

Decomposition:
- Package rf_sched_pkg holds:
  - op enum and rf_cmd enum;
  - state enum {IDLE, READ, WRITE, RESP};
  - ADDR_W=5, DATA_W=16, N_REQ=2.
- One natural sub-module: rf_sched_rr_arb2, a 2-way round-robin grant with a last_grant register and an update-on-accept input.
- The ALU and the latency counter stay inline.

Test Plan:
- Reset then WR from req0 (wa=3, wdata=0x1234) -> ready0 at T; rf_cmd=WRITE for T+1..T+16; rsp_valid[0] at T+17 with data 0.
- RD2 from req1 (ra=3, rb=4; RF holds 0x1234 and 0x0010) -> rsp_valid[1] at T+3, rsp_data_a=0x1234, rsp_data_b=0x0010.
- ADD req0 (3+4 -> wa=5) -> READ T+1..T+2, WRITE T+3..T+18 with rf_wdata=0x1244, rsp at T+19 with rsp_data_a=0x1244. SUB 0x0010-0x1234 -> 0xEDDC. SHL with b=20 -> 0.
- Both valid continuously with RD1 ops -> grants alternate 0,1,0,1 starting with 0; ready is never asserted while busy=1.
- Assert rst_n=0 during the WRITE phase of an ADD -> next cycle rf_cmd=IDLE, busy=0, no rsp_valid; a following RD1 of wa returns its old value.
- Op=7 from req1 -> ready at T, rsp_valid[1] at T+1 with zero data, and no rf_cmd activity.
